// File: rtl/render_frame_sequencer.sv
// Per-frame control sequencer for the render clock domain.
// Synchronises the pixel-domain frame pulse and starts a frame only when the
// renderer is idle. Each frame issues the camera packet, starts the triangle
// feeder and steers its triangles onto the camera or model strobe. After the
// renderer drains, the framebuffer is swapped. Rendered and dropped frames
// are counted.
module render_frame_sequencer #(
  parameter int STARTUP_SKIP = 2,
  parameter int DRAIN_QUIET  = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk_render,
  input  logic             rst_render,
  input  logic             frame_pix,
  input  logic             renderer_busy,
  input  logic             feeder_busy,
  input  logic             feeder_valid,
  input  logic             renderer_ready,
  output logic             begin_frame,
  output logic             camera_req,
  output logic             feeder_begin,
  output logic             camera_valid,
  output logic             model_valid,
  output logic             fb_swap,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [2:0]       state_dbg
);

  localparam int SKIP_W  = $clog2(STARTUP_SKIP + 2);
  localparam int QUIET_W = $clog2(DRAIN_QUIET + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAM   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    SWAP  = 3'd4
  } state_t;

  state_t state, state_next;

  (* ASYNC_REG = "TRUE" *) logic s1;
  (* ASYNC_REG = "TRUE" *) logic s2;
  logic s2_d;
  logic tick;

  logic [SKIP_W-1:0]  skip_cnt;
  logic [QUIET_W-1:0] quiet_cnt;
  logic [1:0]         feed_cnt;
  logic               camera_phase;
  logic               drop_inc;
  logic               skip_dec;
  logic               quiet_done;

  // Two-flop synchroniser for the frame pulse, plus a delayed copy for edge detection
  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= frame_pix;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign tick       = s2 & ~s2_d;
  assign quiet_done = (quiet_cnt == QUIET_W'(DRAIN_QUIET - 1)) && !renderer_busy;

  // Next-state decode plus the skip and drop decisions taken on a tick
  always_comb begin
    state_next = state;
    drop_inc   = 1'b0;
    skip_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          if (skip_cnt != '0)     skip_dec = 1'b1;
          else if (renderer_busy) drop_inc = 1'b1;
          else                    state_next = CAM;
        end
      end
      CAM: begin
        drop_inc   = tick;
        state_next = FEED;
      end
      FEED: begin
        drop_inc = tick;
        // Exit is only considered once the feeder has had two cycles to go busy
        if (feed_cnt == 2'd2 && !feeder_busy && !feeder_valid) state_next = DRAIN;
      end
      DRAIN: begin
        drop_inc = tick;
        if (quiet_done) state_next = SWAP;
      end
      SWAP: begin
        drop_inc   = tick;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) state <= IDLE;
    else            state <= state_next;
  end

  // Registered one-cycle pulses decoded from the state being entered
  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) begin
      begin_frame  <= 1'b0;
      camera_req   <= 1'b0;
      feeder_begin <= 1'b0;
      fb_swap      <= 1'b0;
    end else begin
      begin_frame  <= (state_next == CAM);
      camera_req   <= (state_next == CAM);
      feeder_begin <= (state == CAM);
      fb_swap      <= (state_next == SWAP);
    end
  end

  // Startup skip, FEED dwell and DRAIN quiet counters
  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) begin
      skip_cnt  <= SKIP_W'(STARTUP_SKIP);
      feed_cnt  <= 2'd0;
      quiet_cnt <= '0;
    end else begin
      if (skip_dec) skip_cnt <= skip_cnt - SKIP_W'(1);
      if (state != FEED)         feed_cnt <= 2'd0;
      else if (feed_cnt != 2'd2) feed_cnt <= feed_cnt + 2'd1;
      if (state != DRAIN || renderer_busy) quiet_cnt <= '0;
      else                                 quiet_cnt <= quiet_cnt + QUIET_W'(1);
    end
  end

  // Camera phase: set by CAM (wins over a same-cycle handshake), cleared by the first handshake
  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render)                          camera_phase <= 1'b0;
    else if (state == CAM)                   camera_phase <= 1'b1;
    else if (feeder_valid && renderer_ready) camera_phase <= 1'b0;
  end

  // Frame and drop statistics, wrapping at their width
  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (state == SWAP) frame_count <= frame_count + CNT_W'(1);
      if (drop_inc)      drop_count  <= drop_count + CNT_W'(1);
    end
  end

  assign camera_valid = feeder_valid &  camera_phase & ~rst_render;
  assign model_valid  = feeder_valid & ~camera_phase & ~rst_render;
  assign state_dbg    = state;

endmodule
